// File: rtl/tt_um_sliced_adder_pkg.sv
// Shared definitions for the sliced adder: request modes, FSM encoding and
// the signed-overflow rule used on the effective operands.
package tt_um_sliced_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Two's-complement overflow: like-signed operands producing an unlike-signed result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/tt_um_sliced_adder_slice.sv
// Combinational ripple-carry adder over one SLICE-bit chunk, built from
// full-adder cells; reused by the top on every BUSY cycle.
module adder_slice
  import tt_um_sliced_adder_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/tt_um_sliced_adder.sv
// Multi-cycle adder/subtractor/accumulator that processes SLICE bits per clock
// through a single shared slice adder, with valid/ready handshakes on both sides.
module tt_um_sliced_adder
  import tt_um_sliced_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = (WIDTH'(1) << SLICE) - WIDTH'(1);

  if (SLICE == 0) begin : g_bad_slice
    $error("tt_um_sliced_adder: SLICE must be at least 1");
  end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("tt_um_sliced_adder: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  mode_e            req_mode;
  int unsigned      base;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout;
  logic [WIDTH-1:0] res_next;

  assign req_mode = mode_e'(mode);

  // Select the operand bits for the current slice and splice its result back in.
  always_comb begin
    base     = 32'(k_q) * SLICE;
    sl_a     = SLICE'(op_a_q >> base);
    sl_b     = SLICE'(op_b_q >> base);
    res_next = (res_q & ~(SLICE_MASK << base)) | (WIDTH'(sl_s) << base);
  end

  adder_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .cout(sl_cout)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    k_d      = k_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Latch the effective operands so later input changes cannot disturb the op.
          mode_d  = req_mode;
          k_d     = '0;
          res_d   = '0;
          op_a_d  = (req_mode == MODE_ACC) ? acc_q : a;
          op_b_d  = (req_mode == MODE_SUB) ? ~b : b;
          carry_d = (req_mode == MODE_SUB) ? 1'b1 : cin;
          if (req_mode == MODE_CLR) begin
            state_d = ST_DONE;
            acc_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        res_d   = res_next;
        carry_d = sl_cout;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
          k_d     = '0;
          sum_d   = res_next;
          cout_d  = sl_cout;
          ovf_d   = signed_ovf(op_a_q[WIDTH-1], op_b_q[WIDTH-1], res_next[WIDTH-1]);
          if (mode_q == MODE_ACC) begin
            acc_d = res_next;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ADD;
      k_q         <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tt_um_sliced_adder.sv
// Randomized and directed bench for tt_um_sliced_adder (WIDTH=8, SLICE=4)
// against an integer-arithmetic reference model.
module tb_tt_um_sliced_adder;
  import tt_um_sliced_adder_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  tt_um_sliced_adder #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks;
  int          n_fail;
  bit          cmp_en;
  int unsigned m_acc;
  logic [7:0]  cur_sum, new_sum;
  logic        cur_cout, new_cout, cur_ovf, new_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int s8(input int unsigned x);
    return (x >= 128) ? int'(x) - 256 : int'(x);
  endfunction

  // Reference result from plain integer arithmetic on the requested operation.
  task automatic model(input logic [1:0] md, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic);
    int unsigned ua, ub, full;
    int sv;
    ua = (md == MODE_ACC) ? m_acc : 32'(ia);
    ub = 32'(ib);
    case (md)
      MODE_SUB: begin
        full     = ua + 32'd256 - ub;
        new_cout = (ua >= ub);
        sv       = s8(ua) - s8(ub);
      end
      MODE_CLR: begin
        full     = 0;
        new_cout = 1'b0;
        sv       = 0;
      end
      default: begin
        full     = ua + ub + 32'(ic);
        new_cout = (full > 32'd255);
        sv       = s8(ua) + s8(ub) + int'(ic);
      end
    endcase
    new_sum = 8'(full);
    new_ovf = (sv > 127) || (sv < -128);
  endtask

  task automatic noise_drive(input bit on);
    if (on) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = 8'($urandom);
      b        = 8'($urandom);
      cin      = 1'($urandom);
      mode     = 2'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_sum"},       32'(sum),       32'(0));
    chk({tag, "_cout"},      32'(cout),      32'(0));
    chk({tag, "_ovf"},       32'(ovf),       32'(0));
  endtask

  // One full transaction, starting just after a rising edge with the DUT idle.
  task automatic do_op(input logic [1:0] md, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input int hold, input bit noise, input bit use_lit,
                       input logic [7:0] l_sum, input logic l_cout, input logic l_ovf);
    int lat;
    mode      = md;
    a         = ia;
    b         = ib;
    cin       = ic;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'(1));
    model(md, ia, ib, ic);
    @(posedge clk); #1;
    noise_drive(noise);
    lat = 0;
    while (!out_valid && lat < 8) begin
      chk("in_ready_busy", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
      noise_drive(noise);
      lat++;
    end
    chk("latency", 32'(lat), (md == MODE_CLR) ? 32'(0) : 32'(NSLICE));
    if (use_lit) begin
      chk("lit_sum",  32'(sum),  32'(l_sum));
      chk("lit_cout", 32'(cout), 32'(l_cout));
      chk("lit_ovf",  32'(ovf),  32'(l_ovf));
    end
    repeat (hold) begin
      chk("hold_out_valid", 32'(out_valid), 32'(1));
      chk("hold_in_ready",  32'(in_ready),  32'(0));
      @(posedge clk); #1;
      noise_drive(noise);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'(0));
    chk("post_in_ready",  32'(in_ready),  32'(1));
    cur_sum  = new_sum;
    cur_cout = new_cout;
    cur_ovf  = new_ovf;
    if (md == MODE_ACC) m_acc = 32'(new_sum);
    if (md == MODE_CLR) m_acc = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cmp_en    = 1'b0;
    m_acc     = 0;
    cur_sum   = '0;
    cur_cout  = 1'b0;
    cur_ovf   = 1'b0;
    new_sum   = '0;
    new_cout  = 1'b0;
    new_ovf   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    mode      = MODE_ADD;

    // Every-cycle comparison: result must show the new value in DONE, else the last one.
    fork
      forever begin
        @(negedge clk);
        if (cmp_en && rst_n) begin
          if (out_valid) begin
            chk("cmp_sum_done",  32'(sum),  32'(new_sum));
            chk("cmp_cout_done", 32'(cout), 32'(new_cout));
            chk("cmp_ovf_done",  32'(ovf),  32'(new_ovf));
          end else begin
            chk("cmp_sum_keep",  32'(sum),  32'(cur_sum));
            chk("cmp_cout_keep", 32'(cout), 32'(cur_cout));
            chk("cmp_ovf_keep",  32'(ovf),  32'(cur_ovf));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    do_op(MODE_ADD, 8'hFF, 8'h01, 1'b0, 0, 0, 1, 8'h00, 1'b1, 1'b0);
    do_op(MODE_ADD, 8'h7F, 8'h00, 1'b1, 1, 1, 1, 8'h80, 1'b0, 1'b1);
    do_op(MODE_SUB, 8'h50, 8'h70, 1'b1, 0, 0, 1, 8'hE0, 1'b0, 1'b0);
    do_op(MODE_SUB, 8'h80, 8'h01, 1'b0, 2, 1, 1, 8'h7F, 1'b1, 1'b1);
    do_op(MODE_CLR, 8'h33, 8'h44, 1'b1, 0, 0, 1, 8'h00, 1'b0, 1'b0);
    do_op(MODE_ACC, 8'hAA, 8'h40, 1'b0, 0, 0, 1, 8'h40, 1'b0, 1'b0);
    do_op(MODE_ACC, 8'h55, 8'h40, 1'b0, 0, 1, 1, 8'h80, 1'b0, 1'b1);
    do_op(MODE_ACC, 8'h00, 8'h40, 1'b0, 0, 0, 1, 8'hC0, 1'b0, 1'b0);

    // DONE held for five cycles with in_valid pulsing on the request side.
    do_op(MODE_ADD, 8'h21, 8'h13, 1'b0, 5, 1, 1, 8'h34, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_no_accept", 32'(out_valid), 32'(0));
    end

    // Asynchronous reset in the middle of a BUSY phase.
    mode     = MODE_ADD;
    a        = 8'h12;
    b        = 8'h34;
    cin      = 1'b0;
    in_valid = 1'b1;
    chk("rst_in_ready_idle", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    #2;
    chk_reset_outputs("midbusy_reset");
    @(posedge clk); #1;
    rst_n    = 1'b1;
    cur_sum  = '0;
    cur_cout = 1'b0;
    cur_ovf  = 1'b0;
    m_acc    = 0;
    cmp_en   = 1'b1;
    do_op(MODE_ACC, 8'hAA, 8'h05, 1'b0, 0, 0, 1, 8'h05, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_sliced_adder.md
TT_UM_SLICED_ADDER -- requirements
Module: tt_um_sliced_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter SLICE, default 4, bits added per clock cycle; NSLICE = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a  input  WIDTH  operand A (ignored in ACC mode).
REQ-006 b  input  WIDTH  operand B.
REQ-007 cin  input  1  carry-in (ADD/ACC only).
REQ-008 mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-009 in_valid / in_ready  input / output  1 each  request handshake.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  final carry (SUB: 1 = no borrow).
REQ-012 ovf  output  1  two's-complement signed overflow.
REQ-013 out_valid / out_ready  output / input  1 each  result handshake.

Function
REQ-014 FSM states IDLE, BUSY, DONE shall exist; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept = in_valid && in_ready; on accept a, b, cin and mode SHALL be latched, slice index set to 0, FSM to BUSY (CLR: to DONE).
REQ-016 Effective operands: ADD A=a, B=b, Cin=cin; SUB A=a, B=~b, Cin=1 (cin ignored); ACC A=acc, B=b, Cin=cin.
REQ-017 In BUSY, each cycle SHALL add slice k (bits k*SLICE..k*SLICE+SLICE-1) with the registered carry, store the slice result and carry, increment k.
REQ-018 After slice NSLICE-1 the FSM SHALL enter DONE; out_valid SHALL rise exactly NSLICE cycles after the accept edge.
REQ-019 cout SHALL equal the final slice carry; ovf = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]) using effective operands.
REQ-020 Results are modulo 2^WIDTH; no saturation.
REQ-021 ACC: internal accumulator acc SHALL be loaded with sum on entry to DONE.
REQ-022 CLR: acc, sum, cout, ovf SHALL be cleared; DONE reached 1 cycle after accept.
REQ-023 sum, cout, ovf SHALL hold stable while out_valid=1 and out_ready=0 (any duration).
REQ-024 In DONE with out_ready=1 the FSM SHALL return to IDLE next edge; no accept in the same cycle (throughput one op per NSLICE+2 cycles minimum).
REQ-025 in_valid while BUSY or DONE SHALL be ignored with no state change.
REQ-026 sum/cout/ovf SHALL retain the last completed result while IDLE and BUSY until the next DONE entry.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, acc=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, k=0, including mid-BUSY.
REQ-028 After rst_n release, first accept is possible on the first rising edge.

Structure
REQ-029 Shared package tt_um_sliced_adder_pkg SHALL hold mode constants (MODE_ADD/SUB/ACC/CLR) and FSM state encoding.
REQ-030 One sub-module adder_slice (parametrised SLICE, combinational ripple of full-adder cells: a, b, cin -> s, cout) SHALL be instantiated once and reused every cycle.
REQ-031 WIDTH not a multiple of SLICE, or SLICE<1, SHALL cause an elaboration error.

Verification (WIDTH=8, SLICE=4)
REQ-032 ADD a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ovf=0, out_valid 2 cycles after accept; ADD 0x7F+0x00 cin=1 -> 0x80 ovf=1.
REQ-033 SUB 0x50-0x70 -> 0xE0 cout=0 ovf=0; SUB 0x80-0x01 -> 0x7F cout=1 ovf=1.
REQ-034 CLR, then ACC b=0x40 cin=0 three times -> 0x40, 0x80 (ovf=1), 0xC0 (ovf=0).
REQ-035 out_ready low 5 cycles in DONE with in_valid pulsing -> sum/out_valid held, in_ready=0, no new op accepted.
REQ-036 rst_n low during BUSY of ADD 0x12+0x34 -> all outputs reset values asynchronously, acc=0, in_ready=1; subsequent ACC b=0x05 -> 0x05.
